// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the serial arithmetic family (adder/subtractor/
// comparator). Holds the controller state encoding, the default operand
// width, and the single-bit subtract equations used by the datapath cell.
// -----------------------------------------------------------------------------
package serial_arith_pkg;

    // Default operand width shared with the adder family.
    localparam int ARITH_WIDTH = 16;

    // Controller state encoding for the start/done handshake units.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Difference bit of a one-bit full subtractor: a - b - bin.
    function automatic logic fs_diff(input logic a, input logic b, input logic bin);
        return a ^ b ^ bin;
    endfunction

    // Borrow out of a one-bit full subtractor: a - b - bin.
    function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
        return (~a & b) | (~(a ^ b) & bin);
    endfunction

endpackage : serial_arith_pkg

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit combinational subtract cell computing a - b - bin.
// Kept as its own module so the same cell can back a future serial comparator.
//
// Ports:
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in from the previous (less significant) bit
//   d    : difference bit
//   bout : borrow out to the next (more significant) bit
// -----------------------------------------------------------------------------
module full_subtractor
    import serial_arith_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = fs_diff(a, b, bin);
    assign bout = fs_borrow(a, b, bin);

endmodule : full_subtractor

// File: rtl/serial_sub16.sv
// -----------------------------------------------------------------------------
// serial_sub16
// Bit-serial unsigned subtractor behind a start/done handshake. Computes
// out = in1 - in2 (mod 2^WIDTH), one bit per clock, LSB first, through a
// single full_subtractor cell. underflow is the final borrow (in1 < in2).
//
// Timing: start accepted on edge k; bits are processed on edges k+1..k+WIDTH;
// done is high for the single cycle following edge k+WIDTH, with out and
// underflow already valid. out/underflow then hold until the next accept.
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : request, sampled only while idle
//   in1, in2  : minuend / subtrahend, captured on the accept edge
//   busy      : high while a request is in progress
//   done      : one-cycle result-valid pulse
//   out       : difference in1 - in2 mod 2^WIDTH
//   underflow : final borrow out
// -----------------------------------------------------------------------------
module serial_sub16
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             underflow
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [WIDTH-1:0] ZERO_W   = WIDTH'(0);

    state_e             state_r;
    state_e             state_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   res_r;
    logic               borrow_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   out_r;
    logic               underflow_r;
    logic               busy_r;
    logic               done_r;
    logic               busy_s;
    logic               done_s;
    logic               d_s;
    logic               bout_s;
    logic               last_bit_s;

    // The single datapath cell sees the current LSBs and the running borrow.
    full_subtractor u_fs (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .bin  (borrow_r),
        .d    (d_s),
        .bout (bout_s)
    );

    assign last_bit_s = (cnt_r == LAST_CNT) ? 1'b1 : 1'b0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: start is only looked at in IDLE, DONE always returns.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_RUN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_bit_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state, so busy/done can be registered
    // and still line up exactly with the state they describe.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_s)
            S_IDLE: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            S_RUN: begin
                busy_s = 1'b1;
                done_s = 1'b0;
            end
            S_DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    // Serial datapath: operand load on accept, one bit per RUN edge, and the
    // visible result is only written on the final bit so out never shows a
    // partially built difference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= ZERO_W;
            b_r         <= ZERO_W;
            res_r       <= ZERO_W;
            borrow_r    <= 1'b0;
            cnt_r       <= CNT_ZERO;
            out_r       <= ZERO_W;
            underflow_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        a_r         <= in1;
                        b_r         <= in2;
                        res_r       <= ZERO_W;
                        borrow_r    <= 1'b0;
                        cnt_r       <= CNT_ZERO;
                        out_r       <= ZERO_W;
                        underflow_r <= 1'b0;
                    end else begin
                        a_r         <= a_r;
                        b_r         <= b_r;
                        res_r       <= res_r;
                        borrow_r    <= borrow_r;
                        cnt_r       <= cnt_r;
                        out_r       <= out_r;
                        underflow_r <= underflow_r;
                    end
                end
                S_RUN: begin
                    // LSB-first: new bit enters at the MSB, so after WIDTH
                    // shifts bit i sits in position i.
                    a_r      <= {1'b0, a_r[WIDTH-1:1]};
                    b_r      <= {1'b0, b_r[WIDTH-1:1]};
                    res_r    <= {d_s, res_r[WIDTH-1:1]};
                    borrow_r <= bout_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (last_bit_s) begin
                        out_r       <= {d_s, res_r[WIDTH-1:1]};
                        underflow_r <= bout_s;
                    end else begin
                        out_r       <= out_r;
                        underflow_r <= underflow_r;
                    end
                end
                default: begin
                    a_r         <= a_r;
                    b_r         <= b_r;
                    res_r       <= res_r;
                    borrow_r    <= borrow_r;
                    cnt_r       <= cnt_r;
                    out_r       <= out_r;
                    underflow_r <= underflow_r;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign out       = out_r;
    assign underflow = underflow_r;

endmodule : serial_sub16

// File: tb/tb_serial_sub16.sv
// -----------------------------------------------------------------------------
// tb_serial_sub16
// Self-checking bench for serial_sub16 (WIDTH=16). A transaction-level model
// tracks busy/done/out/underflow from the handshake rules and plain unsigned
// arithmetic; a compare process checks the DUT against it every cycle, and
// directed vectors pin results and latency to hand-computed literals.
// -----------------------------------------------------------------------------
module tb_serial_sub16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] in1 = 16'h0000;
    logic [W-1:0] in2 = 16'h0000;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         underflow;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    logic checking = 1'b0;

    serial_sub16 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in1       (in1),
        .in2       (in2),
        .busy      (busy),
        .done      (done),
        .out       (out),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: counts edges since acceptance; result computed with
    // ordinary unsigned subtraction/comparison.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_out  = 16'h0000;
    logic         m_uf   = 1'b0;
    int           m_age  = 0;
    logic [W-1:0] m_op1  = 16'h0000;
    logic [W-1:0] m_op2  = 16'h0000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_out <= 16'h0000; m_uf <= 1'b0; m_age <= 0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (start) begin
                m_busy <= 1'b1; m_age <= 0; m_out <= 16'h0000; m_uf <= 1'b0;
                m_op1 <= in1; m_op2 <= in2;
            end
        end else begin
            m_age <= m_age + 1;
            if (m_age + 1 == W) begin
                m_done <= 1'b1;
                m_out  <= m_op1 - m_op2;
                m_uf   <= (m_op1 < m_op2);
            end else if (m_age + 1 == W + 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
            end else begin
                m_done <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            check("busy", {15'h0, busy}, {15'h0, m_busy});
            check("done", {15'h0, done}, {15'h0, m_done});
            check("out", out, m_out);
            check("underflow", {15'h0, underflow}, {15'h0, m_uf});
            if (done === 1'b1) done_pulses++;
        end
    end

    // Drive a request, count edges (accept edge = 1) until done, check result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_out, input logic exp_uf);
        int n;
        @(negedge clk);
        in1 = a; in2 = b; start = 1'b1;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", {15'h0, busy}, 16'h0001);
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("latency_edges", 16'(n), 16'd17);
        check("result_out", out, exp_out);
        check("result_uf", {15'h0, underflow}, {15'h0, exp_uf});
        check("model_out", m_out, exp_out);
        @(negedge clk);
        check("done_one_cycle", {15'h0, done}, 16'h0000);
        check("out_held", out, exp_out);
    endtask

    initial begin
        int p0;
        int t0;
        int t1;
        // 1: reset, then idle for 20 cycles
        repeat (2) @(negedge clk);
        checking = 1'b1;
        check("reset_out", out, 16'h0000);
        check("reset_busy", {15'h0, busy}, 16'h0000);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_out", out, 16'h0000);

        // 2-4: arithmetic vectors
        run_op(16'h0005, 16'h0003, 16'h0002, 1'b0);
        run_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1);
        run_op(16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);
        run_op(16'h00C7, 16'h0061, 16'h0066, 1'b0);
        run_op(16'h0001, 16'hFFFF, 16'h0002, 1'b1);
        run_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0);

        // 5: operand changes and start pulses during RUN are ignored
        p0 = done_pulses;
        @(negedge clk);
        in1 = 16'h0081; in2 = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        in1 = 16'h1234; in2 = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("ignore_out", out, 16'h0081);
        check("ignore_uf", {15'h0, underflow}, 16'h0000);
        check("single_done", 16'(done_pulses - p0), 16'd1);

        // Back-to-back: start held high gives one result per 18 cycles
        @(negedge clk);
        in1 = 16'h0010; in2 = 16'h0020; start = 1'b1;
        t0 = 0; t1 = 0;
        for (int c = 0; c < 60 && t1 == 0; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (t0 == 0) t0 = c; else t1 = c;
            end
        end
        start = 1'b0;
        check("b2b_spacing", 16'(t1 - t0), 16'd18);
        check("b2b_out", out, 16'hFFF0);
        repeat (20) @(negedge clk);

        // 6: asynchronous reset after 8 RUN cycles
        p0 = done_pulses;
        in1 = 16'h00FF; in2 = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {15'h0, busy}, 16'h0000);
        check("arst_out", out, 16'h0000);
        check("arst_uf", {15'h0, underflow}, 16'h0000);
        check("arst_done", {15'h0, done}, 16'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("arst_no_done", 16'(done_pulses - p0), 16'd0);
        run_op(16'h0002, 16'h0001, 16'h0001, 1'b0);

        repeat (3) @(negedge clk);
        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_serial_sub16
